// File: rtl/stereo_fade_ctrl.sv
// stereo_fade_ctrl: ramps per-channel gain toward the aural-state target and scales mono samples to L/R.
// Latency: 1 cycle from sample_valid to out_valid; fades advance one STEP per accepted sample.
// Backpressure: none; every sample_valid strobe is accepted and yields exactly one out_valid strobe.
//
// Build option STEREO_FADE_EN:
//   defined   -> gains ramp linearly toward the new target, busy high while ramping,
//                requests arriving mid-fade are queued (last one wins) in a pending register.
//   undefined -> gains load their targets the cycle after a state change, busy tied to 0.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   aural_state[1:0]    requested mode: 11 both, 10 left only, 01 right only, 00 mute
//   sample_in, sample_valid      signed mono sample and its one-cycle strobe
//   left_out, right_out, out_valid   registered scaled samples and their strobe
//   left_gain, right_gain        current gains, 0..2^GAIN_W (unity = 2^GAIN_W)
//   busy                high while a fade is in progress
module stereo_fade_ctrl #(
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 6,
    parameter int STEP     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 aural_state,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    output logic signed [SAMPLE_W-1:0] left_out,
    output logic signed [SAMPLE_W-1:0] right_out,
    output logic                       out_valid,
    output logic [GAIN_W:0]            left_gain,
    output logic [GAIN_W:0]            right_gain,
    output logic                       busy
);

    localparam int              PROD_W   = SAMPLE_W + GAIN_W + 1;
    localparam logic [GAIN_W:0] GAIN_MAX = {1'b1, {GAIN_W{1'b0}}};

    // A ramp must land exactly on 0 and on GAIN_MAX, so STEP has to divide GAIN_MAX.
    if (STEP <= 0 || ((1 << GAIN_W) % STEP) != 0) begin : g_bad_step
        $error("stereo_fade_ctrl: STEP must be a positive divisor of 2**GAIN_W");
    end

    // Target gain per channel: bit 1 of the code enables left, bit 0 enables right.
    function automatic logic [GAIN_W:0] tgt_left(input logic [1:0] code);
        return code[1] ? GAIN_MAX : '0;
    endfunction

    function automatic logic [GAIN_W:0] tgt_right(input logic [1:0] code);
        return code[0] ? GAIN_MAX : '0;
    endfunction

    // Signed sample times unsigned gain, then an arithmetic shift by GAIN_W.
    // The gain is zero-extended before the signed multiply so 64 is not read
    // as a negative number. |sample| * GAIN_MAX fits in PROD_W bits, so the
    // result always fits back into SAMPLE_W bits: no saturation is needed.
    function automatic logic signed [SAMPLE_W-1:0] scale(
        input logic signed [SAMPLE_W-1:0] s,
        input logic [GAIN_W:0]            g
    );
        logic signed [PROD_W-1:0] p;
        p = PROD_W'(s) * $signed(PROD_W'(g));
        return SAMPLE_W'(p >>> GAIN_W);
    endfunction

    // ------------------------------------------------------------------
    // Datapath: one-cycle registered multiply, using the gains as they
    // stand before this cycle's ramp update. Outputs hold between strobes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_out  <= '0;
            right_out <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= sample_valid;
            if (sample_valid) begin
                left_out  <= scale(sample_in, left_gain);
                right_out <= scale(sample_in, right_gain);
            end
        end
    end

`ifdef STEREO_FADE_EN

    localparam logic [GAIN_W:0] GAIN_STEP = (GAIN_W + 1)'(STEP);

    typedef enum logic {
        STEADY,
        FADING
    } fade_state_t;

    fade_state_t     state;
    logic [1:0]      tgt;        // code currently being faded toward / held
    logic [1:0]      pend;       // most recent request seen while fading
    logic            pend_flag;  // pend holds a request not yet acted on
    logic [GAIN_W:0] nxt_left;
    logic [GAIN_W:0] nxt_right;
    logic            fade_done;

    // Move one STEP toward the target, holding once there.
    function automatic logic [GAIN_W:0] ramp(
        input logic [GAIN_W:0] g,
        input logic [GAIN_W:0] t
    );
        if (g < t) begin
            return g + GAIN_STEP;
        end else if (g > t) begin
            return g - GAIN_STEP;
        end else begin
            return g;
        end
    endfunction

    always_comb begin
        nxt_left  = ramp(left_gain,  tgt_left(tgt));
        nxt_right = ramp(right_gain, tgt_right(tgt));
        fade_done = (nxt_left == tgt_left(tgt)) && (nxt_right == tgt_right(tgt));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= STEADY;
            tgt        <= 2'b11;
            pend       <= 2'b11;
            pend_flag  <= 1'b0;
            left_gain  <= GAIN_MAX;
            right_gain <= GAIN_MAX;
            busy       <= 1'b0;
        end else begin
            case (state)
                STEADY: begin
                    // Gains already sit on the target here, so a sample in
                    // this cycle leaves them alone.
                    if (aural_state != tgt) begin
                        tgt   <= aural_state;
                        state <= FADING;
                        busy  <= 1'b1;
                    end
                end

                FADING: begin
                    if (sample_valid) begin
                        left_gain  <= nxt_left;
                        right_gain <= nxt_right;
                    end

                    if (sample_valid && fade_done) begin
                        // Chain straight into a queued request without a
                        // STEADY cycle; a request that came back to the
                        // current target is simply dropped.
                        pend_flag <= 1'b0;
                        if (pend_flag && (pend != tgt)) begin
                            tgt <= pend;
                        end else begin
                            state <= STEADY;
                            busy  <= 1'b0;
                        end
                    end else if (aural_state != (pend_flag ? pend : tgt)) begin
                        // Any change of request is recorded; the last one wins.
                        pend      <= aural_state;
                        pend_flag <= 1'b1;
                    end
                end

                default: begin
                    state <= STEADY;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`else

    logic [1:0] tgt;  // code whose gains are currently loaded

    // No ramp: a new request loads both gains on the following edge,
    // independent of sample_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt        <= 2'b11;
            left_gain  <= GAIN_MAX;
            right_gain <= GAIN_MAX;
        end else if (aural_state != tgt) begin
            tgt        <= aural_state;
            left_gain  <= tgt_left(aural_state);
            right_gain <= tgt_right(aural_state);
        end
    end

    assign busy = 1'b0;

`endif

endmodule

// File: tb/tb_stereo_fade_ctrl.sv
// tb_stereo_fade_ctrl: scenario tasks plus a randomized run against a rule-level reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives sample_valid strobes freely.
module tb_stereo_fade_ctrl;

    localparam int SW   = 16;
    localparam int GW   = 6;
    localparam int ST   = 1;
    localparam int GMAX = 64;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [1:0]           aural_state = 2'b11;
    logic signed [SW-1:0] sample_in = '0;
    logic                 sample_valid = 1'b0;
    logic signed [SW-1:0] left_out;
    logic signed [SW-1:0] right_out;
    logic                 out_valid;
    logic [GW:0]          left_gain;
    logic [GW:0]          right_gain;
    logic                 busy;

    stereo_fade_ctrl #(.SAMPLE_W(SW), .GAIN_W(GW), .STEP(ST)) dut (
        .clk(clk), .rst(rst), .aural_state(aural_state), .sample_in(sample_in),
        .sample_valid(sample_valid), .left_out(left_out), .right_out(right_out),
        .out_valid(out_valid), .left_gain(left_gain), .right_gain(right_gain), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, updated once per rising edge.
    int         m_lg, m_rg, m_lo, m_ro;
    bit         m_ov, m_fading;
    logic [1:0] m_tgt, m_last;

    // floor(s*g / GMAX) done with plain integer division.
    function automatic int sref(input int s, input int g);
        int p, q;
        p = s * g;
        q = p / GMAX;
        if (p < 0 && (p % GMAX) != 0) q = q - 1;
        return q;
    endfunction

    function automatic int tl(input logic [1:0] c);
        return c[1] ? GMAX : 0;
    endfunction

    function automatic int tr(input logic [1:0] c);
        return c[0] ? GMAX : 0;
    endfunction

    function automatic int toward(input int g, input int t);
        if (g < t) return g + ST;
        if (g > t) return g - ST;
        return g;
    endfunction

    task automatic model_reset();
        m_lg = GMAX; m_rg = GMAX; m_lo = 0; m_ro = 0; m_ov = 0;
        m_fading = 0; m_tgt = 2'b11; m_last = 2'b11;
    endtask

    task automatic model_edge(input logic [1:0] a, input logic v, input int s);
        if (v) begin
            m_lo = sref(s, m_lg);
            m_ro = sref(s, m_rg);
        end
        m_ov = v;
`ifdef STEREO_FADE_EN
        if (!m_fading) begin
            if (a != m_tgt) begin
                m_tgt = a; m_last = a; m_fading = 1;
            end
        end else begin
            if (v) begin
                m_lg = toward(m_lg, tl(m_tgt));
                m_rg = toward(m_rg, tr(m_tgt));
            end
            if (v && m_lg == tl(m_tgt) && m_rg == tr(m_tgt)) begin
                // Fade over: follow the latest request seen during it, if new.
                if (m_last != m_tgt) m_tgt = m_last;
                else m_fading = 0;
            end else begin
                m_last = a;
            end
        end
`else
        if (a != m_tgt) begin
            m_tgt = a; m_lg = tl(a); m_rg = tr(a);
        end
`endif
    endtask

    task automatic step(input logic [1:0] a, input logic v, input int s);
        aural_state  = a;
        sample_valid = v;
        sample_in    = SW'(s);
        @(posedge clk);
        model_edge(a, v, s);
        #1;
    endtask

    task automatic reset_dut();
        aural_state = 2'b11; sample_valid = 1'b0; sample_in = '0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (left_gain !== 7'd64) $display("FAIL reset_lgain: got %0d want 64", left_gain); else n_pass++;
        n_checks++; if (right_gain !== 7'd64) $display("FAIL reset_rgain: got %0d want 64", right_gain); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_ovld: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (left_out !== 16'sd0) $display("FAIL reset_lout: got %0d want 0", left_out); else n_pass++;
        n_checks++; if (right_out !== 16'sd0) $display("FAIL reset_rout: got %0d want 0", right_out); else n_pass++;
        reset_dut();
    endtask

    task automatic test_unity();
        step(2'b11, 1'b0, 0);
        step(2'b11, 1'b1, 1000);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL unity_ovld: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (left_out !== 16'sd1000) $display("FAIL unity_lout: got %0d want 1000", left_out); else n_pass++;
        n_checks++; if (right_out !== 16'sd1000) $display("FAIL unity_rout: got %0d want 1000", right_out); else n_pass++;
        step(2'b11, 1'b0, 555);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL unity_ovld_drop: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (left_out !== 16'sd1000) $display("FAIL unity_hold: got %0d want 1000", left_out); else n_pass++;
        step(2'b11, 1'b1, -32768);
        n_checks++; if (left_out !== -16'sd32768) $display("FAIL unity_minneg_l: got %0d want -32768", left_out); else n_pass++;
        n_checks++; if (right_out !== -16'sd32768) $display("FAIL unity_minneg_r: got %0d want -32768", right_out); else n_pass++;
        step(2'b11, 1'b1, 32767);
        n_checks++; if (left_out !== 16'sd32767) $display("FAIL unity_maxpos: got %0d want 32767", left_out); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int s;
        logic signed [SW-1:0] rs;
        for (int i = 0; i < 20; i++) begin
            rs = SW'($urandom);
            s  = rs;
            step(2'b11, 1'b1, s);
            n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_ovld[%0d]: got %b want 1", i, out_valid); else n_pass++;
            n_checks++; if (left_out !== SW'(s) || right_out !== SW'(s))
                $display("FAIL b2b_out[%0d]: got %0d/%0d want %0d", i, left_out, right_out, s); else n_pass++;
        end
        step(2'b11, 1'b0, 0);
    endtask

`ifdef STEREO_FADE_EN
    task automatic test_fade();
        int s, want;
        reset_dut();
        step(2'b11, 1'b0, 0);
        step(2'b10, 1'b0, 0);
        n_checks++; if (busy !== 1'b1) $display("FAIL fade_busy_rise: got %b want 1", busy); else n_pass++;
        n_checks++; if (right_gain !== 7'd64) $display("FAIL fade_no_sample_hold: got %0d want 64", right_gain); else n_pass++;
        step(2'b10, 1'b0, 0);
        n_checks++; if (right_gain !== 7'd64) $display("FAIL fade_idle_hold: got %0d want 64", right_gain); else n_pass++;
        for (int k = 1; k <= 64; k++) begin
            s = (k == 33) ? -3 : 1000;
            step(2'b10, 1'b1, s);
            want = sref(s, 65 - k);
            n_checks++; if (right_out !== SW'(want)) $display("FAIL fade_rout[%0d]: got %0d want %0d", k, right_out, want); else n_pass++;
            n_checks++; if (left_out !== SW'(s)) $display("FAIL fade_lout[%0d]: got %0d want %0d", k, left_out, s); else n_pass++;
            n_checks++; if (right_gain !== 7'(64 - k)) $display("FAIL fade_rgain[%0d]: got %0d want %0d", k, right_gain, 64 - k); else n_pass++;
            n_checks++; if (busy !== (k < 64)) $display("FAIL fade_busy[%0d]: got %b want %b", k, busy, k < 64); else n_pass++;
            if (k == 2) begin
                n_checks++; if (right_out !== 16'sd984) $display("FAIL fade_r984: got %0d want 984", right_out); else n_pass++;
            end
            if (k == 33) begin
                n_checks++; if (right_out !== -16'sd2) $display("FAIL fade_signed_round: got %0d want -2", right_out); else n_pass++;
            end
            if (k == 64) begin
                n_checks++; if (right_out !== 16'sd15) $display("FAIL fade_r15: got %0d want 15", right_out); else n_pass++;
            end
        end
        step(2'b10, 1'b1, 1000);
        n_checks++; if (right_out !== 16'sd0) $display("FAIL fade_r_zero: got %0d want 0", right_out); else n_pass++;
        n_checks++; if (left_out !== 16'sd1000) $display("FAIL fade_l_after: got %0d want 1000", left_out); else n_pass++;
    endtask

    task automatic test_chain();
        logic [1:0] a;
        int wl, wr;
        reset_dut();
        step(2'b11, 1'b0, 0);
        step(2'b10, 1'b0, 0);
        for (int k = 1; k <= 128; k++) begin
            a = (k <= 20) ? 2'b10 : ((k <= 25) ? 2'b01 : 2'b00);
            step(a, 1'b1, 1000);
            wr = (k < 64) ? 64 - k : 0;
            wl = (k <= 64) ? 64 : 128 - k;
            n_checks++; if (right_gain !== 7'(wr)) $display("FAIL chain_rgain[%0d]: got %0d want %0d", k, right_gain, wr); else n_pass++;
            n_checks++; if (left_gain !== 7'(wl)) $display("FAIL chain_lgain[%0d]: got %0d want %0d", k, left_gain, wl); else n_pass++;
            n_checks++; if (busy !== (k < 128)) $display("FAIL chain_busy[%0d]: got %b want %b", k, busy, k < 128); else n_pass++;
        end
        step(2'b00, 1'b1, 1000);
        n_checks++; if (left_out !== 16'sd0 || right_out !== 16'sd0)
            $display("FAIL chain_mute: got %0d/%0d want 0/0", left_out, right_out); else n_pass++;
    endtask
`else
    task automatic test_instant();
        reset_dut();
        step(2'b11, 1'b0, 0);
        step(2'b01, 1'b0, 0);
        n_checks++; if (left_gain !== 7'd0) $display("FAIL inst_01_l: got %0d want 0", left_gain); else n_pass++;
        n_checks++; if (right_gain !== 7'd64) $display("FAIL inst_01_r: got %0d want 64", right_gain); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL inst_busy: got %b want 0", busy); else n_pass++;
        step(2'b01, 1'b1, 1000);
        n_checks++; if (left_out !== 16'sd0 || right_out !== 16'sd1000)
            $display("FAIL inst_01_out: got %0d/%0d want 0/1000", left_out, right_out); else n_pass++;
        step(2'b10, 1'b0, 0);
        n_checks++; if (left_gain !== 7'd64 || right_gain !== 7'd0)
            $display("FAIL inst_10: got %0d/%0d want 64/0", left_gain, right_gain); else n_pass++;
        step(2'b00, 1'b1, -500);
        n_checks++; if (left_out !== -16'sd500 || right_out !== 16'sd0)
            $display("FAIL inst_gain_before_update: got %0d/%0d want -500/0", left_out, right_out); else n_pass++;
        step(2'b00, 1'b1, -500);
        n_checks++; if (left_out !== 16'sd0 || right_out !== 16'sd0)
            $display("FAIL inst_mute: got %0d/%0d want 0/0", left_out, right_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL inst_busy_end: got %b want 0", busy); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid();
        reset_dut();
        step(2'b11, 1'b0, 0);
        step(2'b00, 1'b0, 0);
        for (int k = 1; k <= 30; k++) step(2'b00, 1'b1, 700);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL rmid_pre_ovld: got %b want 1", out_valid); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (left_gain !== 7'd64 || right_gain !== 7'd64)
            $display("FAIL rmid_gains: got %0d/%0d want 64/64", left_gain, right_gain); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_ovld: got %b want 0", out_valid); else n_pass++;
        aural_state = 2'b11; sample_valid = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        step(2'b11, 1'b1, 1234);
        n_checks++; if (left_out !== 16'sd1234 || right_out !== 16'sd1234)
            $display("FAIL rmid_unity: got %0d/%0d want 1234/1234", left_out, right_out); else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0] a;
        logic       v;
        logic signed [SW-1:0] rs;
        int s;
        reset_dut();
        a = 2'b11;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) a = 2'($urandom);
            v  = ($urandom_range(0, 9) < 6);
            rs = SW'($urandom);
            s  = rs;
            step(a, v, s);
            n_checks++; if (left_gain !== 7'(m_lg)) $display("FAIL rnd_lgain[%0d]: got %0d want %0d", i, left_gain, m_lg); else n_pass++;
            n_checks++; if (right_gain !== 7'(m_rg)) $display("FAIL rnd_rgain[%0d]: got %0d want %0d", i, right_gain, m_rg); else n_pass++;
            n_checks++; if (busy !== m_fading) $display("FAIL rnd_busy[%0d]: got %b want %b", i, busy, m_fading); else n_pass++;
            n_checks++; if (out_valid !== m_ov) $display("FAIL rnd_ovld[%0d]: got %b want %b", i, out_valid, m_ov); else n_pass++;
            n_checks++; if (left_out !== SW'(m_lo)) $display("FAIL rnd_lout[%0d]: got %0d want %0d", i, left_out, m_lo); else n_pass++;
            n_checks++; if (right_out !== SW'(m_ro)) $display("FAIL rnd_rout[%0d]: got %0d want %0d", i, right_out, m_ro); else n_pass++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_unity();
        test_back_to_back();
`ifdef STEREO_FADE_EN
        test_fade();
        test_chain();
`else
        test_instant();
`endif
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
